ws2812_rx: RTL
==============

Name: ws2812_rx

Overview:
- Receiver and decoder for the WS2812 single-wire serial protocol; the counterpart of the ws2812c transmitter.
- Samples a DI line, classifies each high pulse as a 0 or 1 bit by its width, and assembles 24-bit GRB pixels.
- Presents each pixel as red/green/blue bytes with its LED address and a one-cycle valid strobe.
- Detects the latch/reset gap that closes a frame.
- Used for loopback self-test of the LED driver and for receiving colour data from an external controller.

Parameters:
- NUM_LEDS, 8: pixels accepted per frame; pixels beyond this count are dropped.
- ADDR_BITS, 3: width of the address output; must satisfy 2**ADDR_BITS >= NUM_LEDS.
- SYSTEM_CLOCK, 48000000: clk frequency in Hz; all timing thresholds below are derived from it.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- DI  in  1  asynchronous WS2812 serial input.
- address  out  ADDR_BITS  index of the pixel currently on red/green/blue.
- red  out  8  received red byte.
- green  out  8  received green byte.
- blue  out  8  received blue byte.
- pixel_valid  out  1  one-cycle strobe: address/red/green/blue hold a new pixel.
- frame_done  out  1  one-cycle strobe: latch gap detected after at least one bit.
- pixel_count  out  ADDR_BITS+1  pixels received in the last frame, saturating at NUM_LEDS; updated on frame_done.
- error  out  1  one-cycle strobe on any protocol violation.

Behaviour:
- Clock and reset
  - One clock; reset is synchronous and active-low.
  - While reset==0, all outputs are 0 and the FSM is in SYNC.
  - Reset asserted mid-frame discards any partial pixel; nothing is emitted for it.
- Input synchronisation
  - DI passes through a 2-FF synchroniser, then a third register for edge detection.
  - Every duration below is measured on the synchronised signal.
- Derived constants (integer division)
  - T_THRESH = SYSTEM_CLOCK*6/10000000 (28 at 48 MHz).
  - T_MIN = SYSTEM_CLOCK*15/100000000 (7).
  - T_MAX = SYSTEM_CLOCK*15/10000000 (72).
  - T_RESET = SYSTEM_CLOCK/20000 (2400; 50 us).
- Duration counter
  - Width ceil(log2(T_RESET+1)).
  - Clears on every edge of the synchronised signal.
  - Saturates at T_RESET.
- FSM states
  - SYNC: wait for the line to be low for T_RESET cycles, then go to IDLE. High levels restart the count. Protects against starting mid-frame.
  - IDLE: bit_cnt=0, address=0. A rising edge goes to HIGH.
  - HIGH: count the high width.
    - If the count exceeds T_MAX: pulse error, discard the partial pixel, go to SYNC.
    - On a falling edge with width < T_MIN: pulse error (glitch), discard the partial pixel, go to SYNC.
    - Otherwise shift bit = (width > T_THRESH) into a 24-bit shift register, MSB first, then go to LOW.
  - LOW: count the low width.
    - A rising edge returns to HIGH.
    - When the count reaches T_RESET: frame end, go to IDLE.
- Pixel assembly
  - Wire order is G[7:0], R[7:0], B[7:0].
  - When the 24th bit is shifted and the current index < NUM_LEDS, on the next cycle: red/green/blue and address update and pixel_valid=1 for one cycle.
  - The index then increments.
  - Indices >= NUM_LEDS are decoded but not presented (no pixel_valid).
- Latency: pixel_valid is high exactly 4 clk after the falling edge of bit 24 at the DI pin.
- Frame end
  - If bit_cnt==0: pulse frame_done and load pixel_count = min(index, NUM_LEDS).
  - If bit_cnt!=0: pulse error as well as frame_done; the partial pixel is dropped and not counted.
  - Then index, bit_cnt and address reset to 0.
- Output holding
  - red/green/blue/address hold their last value between strobes.
  - pixel_valid and frame_done are never high in the same cycle.

Decomposition:
- Shared package ws2812_pkg holds the timing-constant functions (T_THRESH, T_MIN, T_MAX, T_RESET from SYSTEM_CLOCK) and the bit-order constant.
  - ws2812c uses the same package so transmitter and receiver agree.
- One sub-module is natural: ws2812_pulse_meter.
  - Contains the synchroniser, edge detect and saturating duration counter.
  - Outputs rise, fall, level and duration.
- The FSM and pixel assembly stay in ws2812_rx.

Test Plan:
- Reset to 0 for 5 cycles, then DI low for 2400 cycles, then one pixel G=0x12 R=0xA5 B=0x3C (0: 19 high/41 low; 1: 38 high/22 low) -> address=0, red=0xA5, green=0x12, blue=0x3C, pixel_valid 1 cycle, 4 clk after the last fall.
- 8 pixels followed by 2400 low cycles -> 8 pixel_valid pulses with address 0..7, then frame_done with pixel_count=8, no error.
- 10 pixels in one frame -> 8 pixel_valid pulses, pixel_count=8, no error; the next frame starts again at address 0.
- 5-cycle high glitch after 3 bits of a pixel -> error pulse, no pixel_valid, FSM in SYNC; the next pixel after a 2400-cycle gap decodes correctly.
- Frame ends after 12 bits (low for 2400 cycles) -> error and frame_done in the same cycle, pixel_count=0.
- Reset asserted for 1 cycle mid-pixel, then a valid gap and a full pixel -> only the post-reset pixel is emitted, at address 0; boundary widths of 28 cycles decode as 0 and 29 cycles as 1.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing and bit-order definitions, used by both transmitter and receiver
// so that the two sides derive identical thresholds from the same clock frequency.
package ws2812_pkg;

    localparam int BITS_PER_PIXEL = 24;

    // Enum value is the byte's position on the wire (first byte sent = 0); bits go MSB first.
    typedef enum logic [1:0] {COL_G = 2'd0, COL_R = 2'd1, COL_B = 2'd2} color_e;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_e;

    function automatic int t_thresh(input int sys_clk);
        return int'(longint'(sys_clk) * 6 / 10000000);
    endfunction

    function automatic int t_min(input int sys_clk);
        return int'(longint'(sys_clk) * 15 / 100000000);
    endfunction

    function automatic int t_max(input int sys_clk);
        return int'(longint'(sys_clk) * 15 / 10000000);
    endfunction

    function automatic int t_reset(input int sys_clk);
        return sys_clk / 20000;
    endfunction

    function automatic logic [7:0] grb_byte(input logic [23:0] px, input color_e c);
        case (c)
            COL_G:   return px[23:16];
            COL_R:   return px[15:8];
            default: return px[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Pixel/frame output bundle of the WS2812 receiver.
interface ws2812_rx_if #(
    parameter int ADDR_BITS = 3
);
    logic [ADDR_BITS-1:0] address;
    logic [7:0]           red;
    logic [7:0]           green;
    logic [7:0]           blue;
    logic                 pixel_valid;
    logic                 frame_done;
    logic [ADDR_BITS:0]   pixel_count;
    logic                 error;

    modport master (
        output address, red, green, blue, pixel_valid, frame_done, pixel_count, error
    );

    modport slave (
        input address, red, green, blue, pixel_valid, frame_done, pixel_count, error
    );
endinterface

// File: rtl/ws2812_pulse_meter.sv
// Synchronises the serial input, flags its edges and measures how long the current
// level has been held, saturating at the latch-gap length.
module ws2812_pulse_meter #(
    parameter int DUR_W   = 12,
    parameter int T_RESET = 2400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             di_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic             level_o,
    output logic [DUR_W-1:0] dur_o
);
    localparam logic [DUR_W-1:0] SAT = DUR_W'(T_RESET);

    logic             sync1_q, sync2_q, prev_q;
    logic [DUR_W-1:0] dur_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            dur_q   <= '0;
        end else begin
            sync1_q <= di_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            // Restart at 1 so that in the edge cycle dur_o equals the width just ended.
            if (sync2_q != prev_q) dur_q <= DUR_W'(1);
            else if (dur_q != SAT) dur_q <= dur_q + 1'b1;
        end
    end

    assign rise_o  = sync2_q & ~prev_q;
    assign fall_o  = ~sync2_q & prev_q;
    assign level_o = sync2_q;
    assign dur_o   = dur_q;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: classifies high pulses into bits, assembles GRB pixels and
// reports pixels, latch gaps and protocol violations as single-cycle strobes.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int ADDR_BITS    = 3,
    parameter int SYSTEM_CLOCK = 48000000
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     DI,
    ws2812_rx_if.master px
);
    localparam int T_RESET = t_reset(SYSTEM_CLOCK);
    localparam int DUR_W   = $clog2(T_RESET + 1);

    localparam logic [DUR_W-1:0]   THR_C  = DUR_W'(t_thresh(SYSTEM_CLOCK));
    localparam logic [DUR_W-1:0]   MIN_C  = DUR_W'(t_min(SYSTEM_CLOCK));
    localparam logic [DUR_W-1:0]   MAX_C  = DUR_W'(t_max(SYSTEM_CLOCK));
    localparam logic [DUR_W-1:0]   RST_C  = DUR_W'(T_RESET);
    localparam logic [ADDR_BITS:0] NUM_C  = (ADDR_BITS + 1)'(NUM_LEDS);
    localparam logic [4:0]         LAST_C = 5'(BITS_PER_PIXEL - 1);

    logic             rise, fall, level;
    logic [DUR_W-1:0] dur;

    ws2812_pulse_meter #(.DUR_W(DUR_W), .T_RESET(T_RESET)) u_meter (
        .clk    (clk),
        .reset  (reset),
        .di_i   (DI),
        .rise_o (rise),
        .fall_o (fall),
        .level_o(level),
        .dur_o  (dur)
    );

    rx_state_e            state_q;
    logic [23:0]          sr_q;
    logic [4:0]           bit_cnt_q;
    logic [ADDR_BITS:0]   idx_q;
    logic                 pend_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [7:0]           red_q, grn_q, blu_q;
    logic                 pv_q, fd_q, err_q;
    logic [ADDR_BITS:0]   pc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= SYNC;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            red_q     <= '0;
            grn_q     <= '0;
            blu_q     <= '0;
            pv_q      <= 1'b0;
            fd_q      <= 1'b0;
            err_q     <= 1'b0;
            pc_q      <= '0;
        end else begin
            pv_q   <= 1'b0;
            fd_q   <= 1'b0;
            err_q  <= 1'b0;
            pend_q <= 1'b0;

            // Index saturates at NUM_LEDS, so it doubles as the clipped pixel count.
            if (pend_q && idx_q < NUM_C) begin
                addr_q <= idx_q[ADDR_BITS-1:0];
                red_q  <= grb_byte(sr_q, COL_R);
                grn_q  <= grb_byte(sr_q, COL_G);
                blu_q  <= grb_byte(sr_q, COL_B);
                pv_q   <= 1'b1;
                idx_q  <= idx_q + 1'b1;
            end

            case (state_q)
                SYNC: if (!level && dur >= RST_C) state_q <= IDLE;
                IDLE: begin
                    bit_cnt_q <= '0;
                    idx_q     <= '0;
                    addr_q    <= '0;
                    if (rise) state_q <= HIGH;
                end
                HIGH: begin
                    if (dur > MAX_C || (fall && dur < MIN_C)) begin
                        err_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= SYNC;
                    end else if (fall) begin
                        sr_q    <= {sr_q[22:0], dur > THR_C};
                        state_q <= LOW;
                        if (bit_cnt_q == LAST_C) begin
                            bit_cnt_q <= '0;
                            pend_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_q <= HIGH;
                    end else if (dur >= RST_C) begin
                        fd_q      <= 1'b1;
                        err_q     <= bit_cnt_q != '0;
                        pc_q      <= idx_q;
                        idx_q     <= '0;
                        bit_cnt_q <= '0;
                        addr_q    <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign px.address     = addr_q;
    assign px.red         = red_q;
    assign px.green       = grn_q;
    assign px.blue        = blu_q;
    assign px.pixel_valid = pv_q;
    assign px.frame_done  = fd_q;
    assign px.pixel_count = pc_q;
    assign px.error       = err_q;
endmodule
